drain_collector: RTL and testbench

- Sits directly downstream of one column of MAC processing elements in the systolic array.
- Captures each PE's drain pulse (drain_data_t: data, enable) into a per-row holding slot, arbitrates the slots into a result FIFO, and presents the results on a valid/ready stream.
- Each result is tagged with its row index.
- Counts popped results so it can flag when a full column tile (ROWS results) has been drained.

---
 rtl/drain_collector.sv | 250 +++++++++++++++++++++++++
 tb/tb_drain_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drain_collector.sv
`default_nettype none
// ============================================================================
// Module   : drain_collector
// Purpose  : Collects drain pulses from one column of MAC PEs into per-row
//            holding slots, arbitrates the slots (lowest row first) into a
//            result FIFO and presents {data, row} on a valid/ready stream.
//            Counts popped results and pulses tile_done_o once per ROWS pops.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-low
//   clear_i      in   synchronous flush of slots, FIFO, counters, error flag
//   drain_i      in   ROWS drain channels {data, enable}
//   res_data_o   out  data of FIFO head
//   res_row_o    out  row index of FIFO head
//   res_valid_o  out  FIFO head valid
//   res_ready_i  in   consumer accepts head (pop on valid && ready)
//   tile_done_o  out  one-cycle pulse after every ROWS-th pop
//   overflow_o   out  sticky: a drain pulse was lost on a busy slot
//   drop_count_o out  saturating count of lost pulses
// Build option
//   DRAIN_COLLECTOR_DROP_CNT_EN : when defined, drop_count_o counts lost
//                                 pulses; otherwise it is tied to zero.
// ============================================================================

package drain_collector_pkg;
  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  enable;
  } drain_data_t;
endpackage

module drain_collector
  import drain_collector_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  drain_data_t [ROWS-1:0] drain_i,
  output logic [DATA_WIDTH-1:0]  res_data_o,
  output logic [ROW_W-1:0]       res_row_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   tile_done_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       drop_count_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int ENTRY_W = DATA_WIDTH + ROW_W;
  localparam int PCNT_W  = $clog2(ROWS + 1);

  // Per-row holding slots
  logic [ROWS-1:0]       pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_data_q [ROWS];
  logic [DATA_WIDTH-1:0] pend_data_d [ROWS];

  // Arbiter
  logic [ROWS-1:0]       gnt;
  logic [ROWS-1:0]       drop;
  logic                  arb_found;
  logic [ROW_W-1:0]      gnt_row;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  push, pop, full, can_accept;

  // FIFO storage, pointers and registered head
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  head_valid_q, head_valid_d;
  logic [ENTRY_W-1:0]    head_q, head_d;

  // Tile tracking and error flag
  logic [PCNT_W-1:0]     pop_cnt_q, pop_cnt_d;
  logic                  tile_done_q, tile_done_d;
  logic                  overflow_q, overflow_d;

  assign pop  = head_valid_q & res_ready_i;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO can still take a push when the head leaves this cycle.
  assign can_accept = !full || pop;

  // Fixed-priority arbiter: lowest pending row wins when the FIFO has room.
  always_comb begin
    gnt       = '0;
    gnt_row   = '0;
    gnt_data  = '0;
    arb_found = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (pend_q[r] && !arb_found) begin
        arb_found = 1'b1;
        if (can_accept) begin
          gnt[r]   = 1'b1;
          gnt_row  = ROW_W'(r);
          gnt_data = pend_data_q[r];
        end
      end
    end
  end

  assign push = |gnt;

  // Slot update. A pulse on a slot that is being granted this cycle refills
  // it; a pulse on an occupied, non-granted slot is lost and the old value
  // is kept.
  always_comb begin
    pend_d = pend_q;
    drop   = '0;
    for (int r = 0; r < ROWS; r++) begin
      pend_data_d[r] = pend_data_q[r];
      if (drain_i[r].enable) begin
        if (pend_q[r] && !gnt[r]) begin
          drop[r] = 1'b1;
        end else begin
          pend_d[r]      = 1'b1;
          pend_data_d[r] = drain_i[r].data;
        end
      end else if (gnt[r]) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  // FIFO next state. The head register is reloaded from storage at the next
  // read pointer; when that slot is the one being written this cycle the
  // pushed entry is forwarded so a push into an empty FIFO is visible next
  // cycle.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    head_valid_d = (wr_ptr_d != rd_ptr_d);
    head_d       = '0;
    if (head_valid_d) begin
      if (rd_ptr_d == wr_ptr_q) begin
        head_d = {gnt_data, gnt_row};
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Pop counter wraps after ROWS pops and raises tile_done for one cycle.
  always_comb begin
    pop_cnt_d   = pop_cnt_q;
    tile_done_d = 1'b0;
    if (pop) begin
      if (pop_cnt_q == PCNT_W'(ROWS - 1)) begin
        pop_cnt_d   = '0;
        tile_done_d = 1'b1;
      end else begin
        pop_cnt_d = pop_cnt_q + PCNT_W'(1);
      end
    end
  end

  assign overflow_d = overflow_q | (|drop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q       <= '0;
      for (int r = 0; r < ROWS; r++) pend_data_q[r] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      pop_cnt_q    <= '0;
      tile_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (clear_i) begin
      pend_q       <= '0;
      for (int r = 0; r < ROWS; r++) pend_data_q[r] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      pop_cnt_q    <= '0;
      tile_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      for (int r = 0; r < ROWS; r++) pend_data_q[r] <= pend_data_d[r];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      pop_cnt_q    <= pop_cnt_d;
      tile_done_q  <= tile_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {gnt_data, gnt_row};
    end
  end

`ifdef DRAIN_COLLECTOR_DROP_CNT_EN
  localparam int SUM_W = ((CNT_W > PCNT_W) ? CNT_W : PCNT_W) + 1;

  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PCNT_W-1:0] n_drop;
  logic [SUM_W-1:0]  drop_sum;

  // Several rows may collide in the same cycle; add them all, saturating.
  always_comb begin
    n_drop = '0;
    for (int r = 0; r < ROWS; r++) n_drop = n_drop + PCNT_W'(drop[r]);
    drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(n_drop);
    if (drop_sum > SUM_W'({CNT_W{1'b1}})) begin
      drop_cnt_d = '1;
    end else begin
      drop_cnt_d = drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

  assign res_valid_o = head_valid_q;
  assign res_data_o  = head_q[ENTRY_W-1:ROW_W];
  assign res_row_o   = head_q[ROW_W-1:0];
  assign tile_done_o = tile_done_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_drain_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_drain_collector
// Purpose  : Directed self-checking bench for drain_collector (ROWS=4,
//            FIFO_DEPTH=8, CNT_W=8). Inputs change 1 ns after the rising
//            edge; outputs are sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drain_collector;
  import drain_collector_pkg::*;

  localparam int ROWS       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clear;
  logic                   ready;
  drain_data_t [ROWS-1:0] drain;
  logic [DATA_WIDTH-1:0]  res_data;
  logic [1:0]             res_row;
  logic                   res_valid;
  logic                   tile_done;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  int t4_row [8] = '{0, 2, 3, 0, 2, 3, 0, 2};

  always #5 clk = ~clk;

  drain_collector #(
    .ROWS       (ROWS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .clear_i      (clear),
    .drain_i      (drain),
    .res_data_o   (res_data),
    .res_row_o    (res_row),
    .res_valid_o  (res_valid),
    .res_ready_i  (ready),
    .tile_done_o  (tile_done),
    .overflow_o   (overflow),
    .drop_count_o (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input int d, input int r);
    chk({tag, ".valid"}, res_valid, v);
    if (v) begin
      chk({tag, ".data"}, res_data, d);
      chk({tag, ".row"}, res_row, r);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int r, input int d);
    drain[r].enable = 1'b1;
    drain[r].data   = DATA_WIDTH'(d);
  endtask

  task automatic idle_drain;
    drain = '0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    ready = 1'b1;
    drain = '0;
    repeat (3) tick;

    // Reset state
    chk("rst.valid", res_valid, 1'b0);
    chk("rst.data", res_data, 0);
    chk("rst.row", res_row, 0);
    chk("rst.tile_done", tile_done, 1'b0);
    chk("rst.overflow", overflow, 1'b0);
    chk("rst.drop_count", drop_count, 0);
    rst_n = 1'b1;
    tick;

    // 1: single pulse on row 2, visible two cycles later for one cycle
    pulse(2, 16'h0015);
    tick;
    idle_drain;
    chk("t1.valid_t1", res_valid, 1'b0);
    tick;
    chk_head("t1.head", 1'b1, 16'h0015, 2);
    tick;
    chk("t1.valid_t3", res_valid, 1'b0);

    // 2: all rows at once, drained in row order, then tile_done
    do_clear;
    for (int r = 0; r < ROWS; r++) pulse(r, r + 1);
    tick;
    idle_drain;
    tick;
    for (int k = 0; k < ROWS; k++) begin
      chk_head("t2.head", 1'b1, k + 1, k);
      chk("t2.tile_done_low", tile_done, 1'b0);
      tick;
    end
    chk("t2.tile_done_pulse", tile_done, 1'b1);
    chk("t2.valid_after", res_valid, 1'b0);
    tick;
    chk("t2.tile_done_one_cycle", tile_done, 1'b0);

    // 3: ten pulses with ready low: 8 queued, 2 pending, then full drain
    do_clear;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_drain;
      pulse(i % 4, 16'h0030 + i);
      tick;
    end
    idle_drain;
    tick;
    chk_head("t3.full_head", 1'b1, 16'h0030, 0);
    chk("t3.no_overflow", overflow, 1'b0);
    tick;
    chk_head("t3.hold_head", 1'b1, 16'h0030, 0);
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk_head("t3.drain", 1'b1, 16'h0030 + k, k % 4);
      tick;
    end
    chk("t3.empty", res_valid, 1'b0);
    chk("t3.no_overflow_end", overflow, 1'b0);

    // 4: FIFO full, row 1 pending, second pulse on row 1 is dropped
    do_clear;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle_drain;
      pulse(t4_row[i], 16'h0040 + i);
      tick;
    end
    idle_drain;
    pulse(1, 16'h000A);
    tick;
    chk("t4.overflow_before", overflow, 1'b0);
    idle_drain;
    pulse(1, 16'h000B);
    tick;
    idle_drain;
    chk("t4.overflow_set", overflow, 1'b1);
`ifdef DRAIN_COLLECTOR_DROP_CNT_EN
    chk("t4.drop_count", drop_count, 1);
`else
    chk("t4.drop_count", drop_count, 0);
`endif
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head("t4.drain", 1'b1, 16'h0040 + k, t4_row[k]);
      tick;
    end
    chk_head("t4.kept", 1'b1, 16'h000A, 1);
    tick;
    chk("t4.no_0B", res_valid, 1'b0);
    chk("t4.overflow_sticky", overflow, 1'b1);

    // 5: collision on a slot that is granted in the same cycle
    do_clear;
    chk("t5.overflow_cleared", overflow, 1'b0);
    chk("t5.drop_count_cleared", drop_count, 0);
    ready = 1'b1;
    pulse(1, 16'h0051);
    tick;
    idle_drain;
    pulse(1, 16'h0052);
    tick;
    idle_drain;
    chk_head("t5.first", 1'b1, 16'h0051, 1);
    tick;
    chk_head("t5.second", 1'b1, 16'h0052, 1);
    chk("t5.overflow", overflow, 1'b0);
    tick;
    chk("t5.empty", res_valid, 1'b0);
    chk("t5.overflow_end", overflow, 1'b0);

    // 6: async reset mid-drain, then pop counter restarts from zero
    do_clear;
    ready = 1'b1;
    pulse(3, 16'h0061);
    tick;
    idle_drain;
    tick;
    chk_head("t6.pre_pop", 1'b1, 16'h0061, 3);
    tick;
    ready = 1'b0;
    for (int r = 0; r < 3; r++) pulse(r, 16'h0070 + r);
    tick;
    idle_drain;
    repeat (3) tick;
    chk_head("t6.queued", 1'b1, 16'h0070, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", res_valid, 1'b0);
    chk("t6.rst_data", res_data, 0);
    chk("t6.rst_row", res_row, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6.flushed", res_valid, 1'b0);
    ready = 1'b1;
    for (int r = 0; r < ROWS; r++) pulse(r, 16'h0080 + r);
    tick;
    idle_drain;
    tick;
    for (int k = 0; k < ROWS; k++) begin
      chk_head("t6.drain", 1'b1, 16'h0080 + k, k);
      chk("t6.tile_done_low", tile_done, 1'b0);
      tick;
    end
    chk("t6.tile_done_pulse", tile_done, 1'b1);
    tick;
    chk("t6.tile_done_one_cycle", tile_done, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
